// File: rtl/spram_pkg.sv
// Shared constants and types for the single-port RAM round-robin arbiter.
package spram_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RD_CAP = 2'd3
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes.
module rr_pick2
    import spram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = REQ_A;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = REQ_B;
        end
    end

endmodule

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Owns the RAM data-bus tri-state; each access runs as a short FSM transaction.
module spram_rr_arbiter
    import spram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    state_t              state;
    state_t              state_next;
    logic                rr_last;
    logic                pick_valid;
    logic                pick_winner;
    logic                grant;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                cap_id;
    logic [DATA_W-1:0]   cap_wdata;

    rr_pick2 u_pick (
        .req    ({b_req, a_req}),
        .last   (rr_last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Request fields of whichever requester the picker selected.
    always_comb begin
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (pick_winner == REQ_B) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant is decided in IDLE and acknowledged in the same cycle as the capture.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && pick_valid) begin
                    grant      = 1'b1;
                    state_next = win_we ? WR : RD;
                end
            end
            WR:      state_next = IDLE;
            RD:      state_next = RD_CAP;
            RD_CAP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign a_gnt = grant && (pick_winner == REQ_A);
    assign b_gnt = grant && (pick_winner == REQ_B);

    // Capture the winning request; the requester is free to change its inputs afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last   <= REQ_B;
            cap_id    <= REQ_A;
            ram_addr  <= '0;
            cap_wdata <= '0;
        end else if (grant) begin
            rr_last   <= pick_winner;
            cap_id    <= pick_winner;
            ram_addr  <= win_addr;
            cap_wdata <= win_wdata;
        end
    end

    // RAM strobes are registered off the next state so they line up with WR / RD / RD_CAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_wr_en <= 1'b0;
            ram_rd_en <= 1'b0;
        end else begin
            ram_wr_en <= (state_next == WR);
            ram_rd_en <= (state_next == RD) || (state_next == RD_CAP);
        end
    end

    assign ram_data = ram_wr_en ? cap_wdata : {DATA_W{1'bz}};

    // Read data is sampled at the edge that ends RD_CAP and returned only to the owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (state == RD_CAP) begin
                if (cap_id == REQ_A) begin
                    a_rdata  <= ram_data;
                    a_rvalid <= 1'b1;
                end else begin
                    b_rdata  <= ram_data;
                    b_rvalid <= 1'b1;
                end
            end
        end
    end

    // Bus exclusivity and single-grant sanity.
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(ram_wr_en && ram_rd_en));
    a_gnt_excl:    assert property (@(posedge clk) !(a_gnt && b_gnt));

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Bench for spram_rr_arbiter: behavioural RAM, transaction-level reference model,
// randomized and directed scenarios.
module tb_spram_rr_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam logic [DW-1:0] BUS_IDLE = '0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .ram_wr_en (ram_wr_en),
        .ram_rd_en (ram_rd_en),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    // Behavioural RAM: writes on wr_en edge, drives read data from the first rd_en edge
    // until rd_en falls. A bench keeper drives BUS_IDLE whenever no strobe is active.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_q   = '0;
    logic          rd_act = 1'b0;
    int            overlap = 0;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_data;
        rd_act <= ram_rd_en;
        if (ram_rd_en) rd_q <= mem[ram_addr];
    end

    assign ram_data = (ram_rd_en && rd_act) ? rd_q :
                      ((!ram_rd_en && !ram_wr_en) ? BUS_IDLE : {DW{1'bz}});

    always @(negedge clk) if (ram_wr_en && ram_rd_en) overlap <= overlap + 1;

    // Reference state
    op_t           qa[$];
    op_t           qb[$];
    logic [DW-1:0] ref_mem [16];
    logic          last_win;
    logic [DW-1:0] held_a, held_b;
    int            gnt_log[$];
    logic [DW-1:0] rd_log_a[$];
    logic [DW-1:0] rd_log_b[$];

    task automatic drive_inputs();
        a_req = (qa.size() > 0);
        b_req = (qb.size() > 0);
        if (a_req) begin
            a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata;
        end else begin
            a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
        end
        if (b_req) begin
            b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata;
        end else begin
            b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
        end
    endtask

    // Runs the queued ops; expected timing comes from the access latencies (write busy 2
    // cycles, read busy 3 cycles, rvalid 3 cycles after grant) and the round-robin rule.
    task automatic run_ops(input int budget);
        int cyc = 0;
        int next_free = 0;
        int n = 0;
        int act_start = -10;
        logic act_we = 1'b0;
        logic [AW-1:0] act_addr = '0;
        logic [DW-1:0] act_wdata = '0;
        int due_a[$];
        int due_b[$];
        logic [DW-1:0] dat_a[$];
        logic [DW-1:0] dat_b[$];
        bit has_a, has_b, exp_g, exp_wr, exp_rd, exp_rva, exp_rvb, busy;
        logic win;
        op_t op;
        gnt_log.delete(); rd_log_a.delete(); rd_log_b.delete();
        @(posedge clk); #1;
        drive_inputs();
        busy = 1'b1;
        while (busy && n < budget) begin
            @(negedge clk);
            has_a = qa.size() > 0;
            has_b = qb.size() > 0;
            exp_g = (cyc >= next_free) && (has_a || has_b);
            win   = (has_a && has_b) ? ~last_win : has_b;
            checks++;
            if (a_gnt !== (exp_g && !win) || b_gnt !== (exp_g && win)) begin
                errors++;
                $display("FAIL gnt cyc %0d: a_gnt=%b b_gnt=%b expected %b %b",
                         cyc, a_gnt, b_gnt, exp_g && !win, exp_g && win);
            end
            exp_wr = act_we && (cyc == act_start + 1);
            exp_rd = !act_we && (cyc == act_start + 1 || cyc == act_start + 2);
            checks++;
            if (ram_wr_en !== exp_wr || ram_rd_en !== exp_rd) begin
                errors++;
                $display("FAIL strobes cyc %0d: wr=%b rd=%b expected %b %b",
                         cyc, ram_wr_en, ram_rd_en, exp_wr, exp_rd);
            end
            if (exp_wr || exp_rd) begin
                checks++;
                if (ram_addr !== act_addr) begin
                    errors++;
                    $display("FAIL ram_addr cyc %0d: got %h expected %h", cyc, ram_addr, act_addr);
                end
            end
            if (exp_wr) begin
                checks++;
                if (ram_data !== act_wdata) begin
                    errors++;
                    $display("FAIL wr_data cyc %0d: got %h expected %h", cyc, ram_data, act_wdata);
                end
            end else if (!exp_rd) begin
                checks++;
                if (ram_data !== BUS_IDLE) begin
                    errors++;
                    $display("FAIL bus_release cyc %0d: got %h expected %h", cyc, ram_data, BUS_IDLE);
                end
            end
            exp_rva = (due_a.size() > 0) && (due_a[0] == cyc);
            exp_rvb = (due_b.size() > 0) && (due_b[0] == cyc);
            checks++;
            if (a_rvalid !== exp_rva || b_rvalid !== exp_rvb) begin
                errors++;
                $display("FAIL rvalid cyc %0d: a=%b b=%b expected %b %b",
                         cyc, a_rvalid, b_rvalid, exp_rva, exp_rvb);
            end
            if (exp_rva) begin
                held_a = dat_a.pop_front();
                void'(due_a.pop_front());
                rd_log_a.push_back(a_rdata);
            end
            if (exp_rvb) begin
                held_b = dat_b.pop_front();
                void'(due_b.pop_front());
                rd_log_b.push_back(b_rdata);
            end
            checks++;
            if (a_rdata !== held_a || b_rdata !== held_b) begin
                errors++;
                $display("FAIL rdata cyc %0d: a=%h b=%h expected %h %h",
                         cyc, a_rdata, b_rdata, held_a, held_b);
            end
            if (exp_g) begin
                if (win) op = qb.pop_front();
                else     op = qa.pop_front();
                gnt_log.push_back(int'(win));
                last_win  = win;
                act_start = cyc;
                act_we    = op.we;
                act_addr  = op.addr;
                act_wdata = op.wdata;
                if (op.we) begin
                    ref_mem[op.addr] = op.wdata;
                    next_free = cyc + 2;
                end else begin
                    next_free = cyc + 3;
                    if (win) begin
                        due_b.push_back(cyc + 3); dat_b.push_back(ref_mem[op.addr]);
                    end else begin
                        due_a.push_back(cyc + 3); dat_a.push_back(ref_mem[op.addr]);
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
            n++;
            drive_inputs();
            busy = (qa.size() > 0) || (qb.size() > 0) || (due_a.size() > 0) ||
                   (due_b.size() > 0) || (cyc < next_free);
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL run_ops timeout: %0d cycles, qa=%0d qb=%0d left", n, qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1; a_wdata = 8'h55;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd2; b_wdata = 8'h66;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wr_en, ram_rd_en} !== 6'b0) begin
                errors++;
                $display("FAIL reset_strobes: got %b expected 000000",
                         {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wr_en, ram_rd_en});
            end
            checks++;
            if (ram_addr !== 4'd0 || a_rdata !== 8'd0 || b_rdata !== 8'd0) begin
                errors++;
                $display("FAIL reset_regs: addr=%h a_rdata=%h b_rdata=%h expected 0 0 0",
                         ram_addr, a_rdata, b_rdata);
            end
            checks++;
            if (ram_data !== BUS_IDLE) begin
                errors++;
                $display("FAIL reset_bus: got %h expected %h", ram_data, BUS_IDLE);
            end
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;
        last_win = 1'b1; held_a = '0; held_b = '0;
    endtask

    task automatic test_single_a();
        qa.push_back('{1'b1, 4'd3, 8'hA5});
        qa.push_back('{1'b0, 4'd3, 8'h00});
        run_ops(50);
        checks++;
        if (gnt_log.size() != 2 || rd_log_a.size() != 1) begin
            errors++;
            $display("FAIL single_counts: grants=%0d reads=%0d expected 2 1", gnt_log.size(), rd_log_a.size());
        end else if (gnt_log[0] != 0 || gnt_log[1] != 0 || rd_log_a[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_data: grants=%0d,%0d rdata=%h expected 0,0 a5",
                     gnt_log[0], gnt_log[1], rd_log_a[0]);
        end
    endtask

    task automatic test_contention();
        qa.push_back('{1'b1, 4'd1, 8'h11});
        run_ops(50);
        qb.push_back('{1'b1, 4'd2, 8'h22});
        run_ops(50);
        for (int i = 0; i < 3; i++) begin
            qa.push_back('{1'b0, 4'd1, 8'h00});
            qb.push_back('{1'b0, 4'd2, 8'h00});
        end
        run_ops(100);
        checks++;
        if (gnt_log.size() != 6 || rd_log_a.size() != 3 || rd_log_b.size() != 3) begin
            errors++;
            $display("FAIL contention_counts: grants=%0d a=%0d b=%0d expected 6 3 3",
                     gnt_log.size(), rd_log_a.size(), rd_log_b.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (gnt_log[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL contention_order[%0d]: got %0d expected %0d", i, gnt_log[i], i % 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rd_log_a[i] !== 8'h11 || rd_log_b[i] !== 8'h22) begin
                    errors++;
                    $display("FAIL contention_data[%0d]: a=%h b=%h expected 11 22", i, rd_log_a[i], rd_log_b[i]);
                end
            end
        end
    endtask

    task automatic test_fill_readback();
        int ov0 = overlap;
        for (int i = 0; i < 16; i++) qa.push_back('{1'b1, AW'(i), DW'(i)});
        run_ops(200);
        for (int i = 0; i < 16; i++) qb.push_back('{1'b0, AW'(i), 8'h00});
        run_ops(200);
        checks++;
        if (rd_log_b.size() != 16) begin
            errors++;
            $display("FAIL fill_count: got %0d expected 16", rd_log_b.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rd_log_b[i] !== DW'(i)) begin
                    errors++;
                    $display("FAIL fill_data[%0d]: got %h expected %h", i, rd_log_b[i], DW'(i));
                end
            end
        end
        checks++;
        if (overlap != ov0) begin
            errors++;
            $display("FAIL fill_overlap: got %0d expected %0d", overlap, ov0);
        end
    endtask

    task automatic test_random();
        op_t op;
        for (int i = 0; i < 48; i++) begin
            op.we    = 1'($urandom_range(0, 1));
            op.addr  = AW'($urandom_range(0, 15));
            op.wdata = DW'($urandom);
            if (i % 2 == 0) qa.push_back(op);
            else            qb.push_back(op);
        end
        run_ops(1000);
        checks++;
        if (gnt_log.size() != 48) begin
            errors++;
            $display("FAIL random_grants: got %0d expected 48", gnt_log.size());
        end
    endtask

    task automatic test_withdrawn();
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h3C; b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL withdrawn_agnt: a=%b b=%b expected 1 0", a_gnt, b_gnt);
        end
        @(posedge clk); #1;
        ref_mem[7] = 8'h3C; last_win = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 4'd9;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_wdata = 8'hEE;
        @(negedge clk);
        checks++;
        if (b_gnt !== 1'b0 || ram_wr_en !== 1'b1 || ram_addr !== 4'd7 || ram_data !== 8'h3C) begin
            errors++;
            $display("FAIL withdrawn_wr: b_gnt=%b wr=%b addr=%h data=%h expected 0 1 7 3c",
                     b_gnt, ram_wr_en, ram_addr, ram_data);
        end
        @(posedge clk); #1;
        b_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt, ram_wr_en, ram_rd_en} !== 4'b0) begin
                errors++;
                $display("FAIL withdrawn_idle: got %b expected 0000", {a_gnt, b_gnt, ram_wr_en, ram_rd_en});
            end
            @(posedge clk); #1;
        end
        qb.push_back('{1'b0, 4'd5, 8'h00});
        qb.push_back('{1'b0, 4'd7, 8'h00});
        run_ops(50);
        checks++;
        if (rd_log_b.size() != 2 || rd_log_b[0] !== ref_mem[5] || rd_log_b[1] !== 8'h3C) begin
            errors++;
            $display("FAIL withdrawn_mem: reads=%0d expected 2 with %h 3c", rd_log_b.size(), ref_mem[5]);
        end
    endtask

    task automatic test_reset_mid_read();
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3; b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt: got %b expected 1", a_gnt);
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_rd_en !== 1'b1 || ram_addr !== 4'd3) begin
            errors++;
            $display("FAIL midrst_rdcap: rd=%b addr=%h expected 1 3", ram_rd_en, ram_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({a_rvalid, b_rvalid, a_gnt, b_gnt, ram_wr_en, ram_rd_en} !== 6'b0 ||
                ram_data !== BUS_IDLE || a_rdata !== 8'd0 || b_rdata !== 8'd0) begin
                errors++;
                $display("FAIL midrst_idle: strobes=%b bus=%h a_rdata=%h b_rdata=%h expected 000000 %h 0 0",
                         {a_rvalid, b_rvalid, a_gnt, b_gnt, ram_wr_en, ram_rd_en}, ram_data,
                         a_rdata, b_rdata, BUS_IDLE);
            end
            @(posedge clk); #1;
        end
        last_win = 1'b1; held_a = '0; held_b = '0;
        qa.push_back('{1'b0, 4'd3, 8'h00});
        run_ops(50);
        checks++;
        if (rd_log_a.size() != 1 || rd_log_a[0] !== ref_mem[3]) begin
            errors++;
            $display("FAIL midrst_reread: reads=%0d expected 1 with %h", rd_log_a.size(), ref_mem[3]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        last_win = 1'b1; held_a = '0; held_b = '0;
        test_reset();
        test_single_a();
        test_contention();
        test_fill_readback();
        test_random();
        test_withdrawn();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spram_rr_arbiter.md
Name: spram_rr_arbiter

Overview:
- Shares one single-port RAM (clk, wr_en, rd_en, bidirectional data bus, addr) between two requesters, A and B.
- Arbitration is round-robin. Each access is sequenced as a short FSM transaction.
- Owns the RAM data-bus tri-state: drives the bus only during write cycles, samples it on reads.
- Sits between client logic and the RAM instance; the RAM module is unchanged.

Parameters:
- ADDR_W, 4, RAM address width (16 locations).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- a_req  in  1  requester A access request; held until a_gnt.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  one-cycle pulse: A request accepted, inputs captured.
- a_rvalid  out  1  one-cycle pulse: a_rdata valid.
- a_rdata  out  DATA_W  A read data, held until next A read completes.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- ram_wr_en  out  1  to RAM wr_en.
- ram_rd_en  out  1  to RAM rd_en.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_data  inout  DATA_W  RAM data bus.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; rr_last=B, so A wins the first tie.
  - All gnt/rvalid=0; ram_wr_en=ram_rd_en=0; ram_addr=0; a_rdata=b_rdata=0.
  - ram_data released (Z).
  - Any in-flight transaction is abandoned with no gnt/rvalid. A write in progress may or may not have landed.
- RAM contract (decided):
  - Write: the RAM writes ram_data at the posedge where wr_en=1.
  - Read: the RAM drives ram_data from the posedge where rd_en=1, valid until rd_en falls.
- FSM states: IDLE, WR, RD, RD_CAP.
- IDLE:
  - If any req: pick the winner. If both request, the winner is the one not equal to rr_last; otherwise the sole requester.
  - Register winner id, we, addr, wdata. Pulse the winner's gnt in the same cycle as the capture. Update rr_last=winner.
  - Next state is WR if we=1, else RD.
  - No req: stay in IDLE, all strobes 0.
- WR (1 cycle):
  - ram_wr_en=1, ram_rd_en=0, ram_addr=captured addr, ram_data driven with captured wdata.
  - Next state: IDLE.
- RD (1 cycle):
  - ram_rd_en=1, ram_wr_en=0, ram_addr=captured addr, ram_data=Z.
  - Next state: RD_CAP.
- RD_CAP (1 cycle):
  - ram_rd_en stays 1 and ram_addr is held.
  - At the posedge ending RD_CAP: sample ram_data into the winner's rdata and pulse the winner's rvalid in the following cycle (registered). The other requester's rdata is unchanged.
  - Next state: IDLE.
- Latency from gnt:
  - Write: committed 1 cycle after gnt.
  - Read: rvalid asserted 3 cycles after gnt.
- Throughput: a write occupies 2 cycles (IDLE+WR); a read occupies 3 cycles (IDLE+RD+RD_CAP). Back-to-back requests are accepted every 2 or 3 cycles.
- Bus exclusivity:
  - ram_data is driven iff state==WR; otherwise Z.
  - ram_wr_en and ram_rd_en are never both 1.
- Fairness: with both requesting continuously, grants strictly alternate A, B, A, B, ...
- Requester-side rules:
  - req dropped before gnt: the request is withdrawn, no side effects.
  - After gnt, the requester may change its inputs; captured values are used.
  - A new request in the same cycle as an rvalid pulse is legal.
- Widths: all address and data paths are pass-through; no arithmetic.

Decomposition:
- Shared package spram_pkg:
  - ADDR_W / DATA_W defaults.
  - FSM state encoding (2-bit enum IDLE=0, WR=1, RD=2, RD_CAP=3).
  - Requester-id constants (REQ_A=0, REQ_B=1).
- Sub-module rr_pick2: 2-way round-robin picker (inputs: req[1:0], last; outputs: valid, winner). Purely combinational.
- FSM, capture registers and tri-state drive stay in spram_rr_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all gnt/rvalid=0, ram_wr_en=ram_rd_en=0, ram_data=Z, a_rdata=b_rdata=0.
- Single write/read, A: write 8'hA5 to addr 3, then read addr 3 -> a_gnt pulses; ram_wr_en high exactly 1 cycle with ram_data=8'hA5, ram_addr=3; a_rvalid pulses 3 cycles after the read gnt with a_rdata=8'hA5.
- Contention: A and B both read continuously (A addr 1 preloaded 8'h11, B addr 2 preloaded 8'h22) -> grants in order A, B, A, B; a_rdata=8'h11, b_rdata=8'h22; b_rdata untouched on A's rvalid and vice versa.
- Fill/readback: A writes i to addr i for i=0..15 while B idle, then B reads 0..15 -> b_rdata sequence 0..15; no cycle with ram_wr_en&&ram_rd_en.
- Reset mid-read: assert rst_n=0 during RD_CAP of an A read -> no a_rvalid; next cycle state=IDLE, strobes 0, ram_data=Z; a subsequent read returns correct data.
- Withdrawn request: B raises b_req for 1 cycle while an A write is in WR, then drops it -> no b_gnt, no RAM access for B.
